// File: rtl/key_debounce_pkg.sv
// Shared definitions for the three-key debouncer: FSM encoding, key indices
// and the default debounce window.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam int NUM_KEYS    = 3;
    localparam int KEY_RESET   = 0;
    localparam int KEY_START   = 1;
    localparam int KEY_DISPLAY = 2;

    // 200 ms at 50 MHz
    localparam int unsigned DEFAULT_DELAY_TIME = 32'd10_000_000;

endpackage

// File: rtl/key_debounce_chan.sv
// One debounced key: input synchronizer, 32-bit window counter and a
// four-state FSM with registered pulse/level outputs.
module key_debounce_chan
    import key_debounce_pkg::*;
#(
    parameter int unsigned DELAY_TIME  = DEFAULT_DELAY_TIME,
    parameter int          SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press_pulse,
    output logic release_pulse,
    output logic key_state
);

    localparam logic [31:0] LAST = 32'(DELAY_TIME - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    state_t                 state;
    logic [31:0]            cnt;

    // Reset loads "released" so a held key looks like a fresh press afterwards
    always_ff @(posedge clk) begin
        if (rst) sync <= '1;
        else     sync <= {sync[SYNC_STAGES-2:0], key_n};
    end

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            key_state     <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (!s) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (s) begin
                        state <= IDLE;
                    end else if (cnt == LAST) begin
                        state       <= PRESSED;
                        press_pulse <= 1'b1;
                        key_state   <= 1'b1;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                PRESSED: begin
                    if (s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (!s) begin
                        state <= PRESSED;
                    end else if (cnt == LAST) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                        key_state     <= 1'b0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Three independent debounced push-buttons (reset, start/pause, display/stop).
// Each channel is a self-contained key_debounce_chan.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int unsigned DELAY_TIME  = DEFAULT_DELAY_TIME,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] key_state
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
        key_debounce_chan #(
            .DELAY_TIME  (DELAY_TIME),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clk           (clk),
            .rst           (rst),
            .key_n         (key_n[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .key_state     (key_state[i])
        );
    end

endmodule
